// File: rtl/histogram_bin_mem.sv
// -----------------------------------------------------------------------------
// histogram_bin_mem
//
// Bin storage for the histogram component. The component's avmm_0_rw master
// reads and writes 64-bit bins here with a fixed read latency (no waitrequest,
// no readdatavalid). The host can also zero every bin in bulk before a run
// (clear engine) and stream every bin out after the run (drain engine).
//
// Optional feature macro: HISTOGRAM_BIN_MEM_ERR_EN
//   defined   : err is a sticky flag, set by any out-of-range AVMM access or
//               any AVMM access while busy; cleared by reset or by an accepted
//               clr_start.
//   undefined : err is tied to 0 and no error logic is built.
//
// Parameters
//   NUM_WORDS  number of 64-bit bins (power of 2, 16..4096)
//   BASE_ADDR  byte address of bin 0 (8-byte aligned)
//   RD_LAT     cycles from avmm_0_rw_read to avmm_0_rw_readdata (1..4)
//
// Ports
//   clock, reset           single clock, synchronous active-high reset
//   avmm_0_rw_address      byte address, bits [2:0] ignored
//   avmm_0_rw_byteenable   per-byte write enable
//   avmm_0_rw_read/write   access strobes, one request per cycle
//   avmm_0_rw_writedata    write data
//   avmm_0_rw_readdata     read data, RD_LAT cycles after the request,
//                          0 for out-of-range or busy reads and in idle cycles
//   clr_start              pulse: zero all bins (wins over drain_start)
//   drain_start            pulse: stream all bins out in index order
//   busy                   clear or drain in progress
//   drain_valid/ready      drain stream handshake
//   drain_data/index/last  bin word, its index, high on the final index
//   err                    sticky access-error flag (see macro above)
//
// Drain handshake: a beat transfers on every rising clock edge where
// drain_valid and drain_ready are both high. Once drain_valid is raised it
// stays high, and drain_data/drain_index/drain_last stay unchanged, until that
// transfer happens. drain_ready may change freely and is never required to
// wait for drain_valid.
// -----------------------------------------------------------------------------
module histogram_bin_mem #(
  parameter int          NUM_WORDS = 256,
  parameter logic [63:0] BASE_ADDR = 64'd0,
  parameter int          RD_LAT    = 1,
  localparam int         AW        = $clog2(NUM_WORDS)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [63:0]   avmm_0_rw_address,
  input  logic [7:0]    avmm_0_rw_byteenable,
  input  logic          avmm_0_rw_read,
  output logic [63:0]   avmm_0_rw_readdata,
  input  logic          avmm_0_rw_write,
  input  logic [63:0]   avmm_0_rw_writedata,
  input  logic          clr_start,
  input  logic          drain_start,
  output logic          busy,
  output logic          drain_valid,
  input  logic          drain_ready,
  output logic [63:0]   drain_data,
  output logic [AW-1:0] drain_index,
  output logic          drain_last,
  output logic          err
);

  // Skid FIFO holds every drain read that may be in flight when the consumer
  // stalls.
  localparam int DEPTH = RD_LAT + 1;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);

  localparam logic [AW-1:0] LAST_IDX    = AW'(NUM_WORDS - 1);
  localparam logic [AW:0]   NUM_WORDS_C = (AW+1)'(NUM_WORDS);
  localparam logic [PW-1:0] LAST_SLOT   = PW'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t state;

  logic [63:0] mem [NUM_WORDS];

  // ---------------------------------------------------------------------------
  // Address decode. BASE_ADDR is 8-byte aligned, so the comparison can be done
  // on word addresses; the byte-offset bits take no part in the decode.
  // ---------------------------------------------------------------------------
  logic [60:0]   word_off;
  logic          in_range;
  logic [AW-1:0] av_idx;
  logic          rd_ok;
  logic          wr_ok;
  logic          unused_addr_lsbs;

  assign word_off         = avmm_0_rw_address[63:3] - BASE_ADDR[63:3];
  assign in_range         = (avmm_0_rw_address[63:3] >= BASE_ADDR[63:3]) &&
                            (word_off < 61'(NUM_WORDS));
  assign av_idx           = word_off[AW-1:0];
  assign unused_addr_lsbs = ^avmm_0_rw_address[2:0];

  assign busy  = (state != ST_IDLE);
  assign rd_ok = avmm_0_rw_read  && in_range && !busy;
  assign wr_ok = avmm_0_rw_write && in_range && !busy;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  logic          clr_go;
  logic          drain_go;
  logic          pop;
  logic [AW-1:0] clr_ptr;

  assign clr_go   = (state == ST_IDLE) && clr_start;
  assign drain_go = (state == ST_IDLE) && drain_start && !clr_start;
  assign pop      = drain_valid && drain_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      clr_ptr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          clr_ptr <= '0;
          if (clr_go) begin
            state <= ST_CLEAR;
          end else if (drain_go) begin
            state <= ST_DRAIN;
          end
        end
        ST_CLEAR: begin
          clr_ptr <= clr_ptr + AW'(1);
          if (clr_ptr == LAST_IDX) begin
            state <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (pop && drain_last) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // RAM write port: clear engine while busy, AVMM otherwise. Contents are
  // deliberately not reset. The clear write is suppressed in a reset cycle so
  // a reset aborts the clear before another word is touched.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset && (state == ST_CLEAR)) begin
      mem[clr_ptr] <= '0;
    end else if (wr_ok) begin
      for (int b = 0; b < 8; b++) begin
        if (avmm_0_rw_byteenable[b]) begin
          mem[av_idx][b*8 +: 8] <= avmm_0_rw_writedata[b*8 +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // AVMM read path: synchronous read (old data on a same-cycle write), then
  // RD_LAT-1 delay stages. Rejected reads carry zero down the pipe.
  // ---------------------------------------------------------------------------
  logic [63:0] rd_pipe [RD_LAT];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        rd_pipe[i] <= '0;
      end
    end else begin
      rd_pipe[0] <= rd_ok ? mem[av_idx] : '0;
      for (int i = 1; i < RD_LAT; i++) begin
        rd_pipe[i] <= rd_pipe[i-1];
      end
    end
  end

  assign avmm_0_rw_readdata = rd_pipe[RD_LAT-1];

  // ---------------------------------------------------------------------------
  // Drain engine. Word 0 is read in the same cycle drain_start is accepted so
  // the first beat is presented two cycles after the start. A read is issued
  // only when the FIFO is guaranteed room for it, counting the word already in
  // flight and a pop happening this cycle.
  // ---------------------------------------------------------------------------
  logic [AW:0]   issue_cnt;
  logic [AW-1:0] drain_rd_addr;
  logic          has_space;
  logic          issue;
  logic [63:0]   drain_q;
  logic          drain_q_vld;
  logic [63:0]   fifo_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] fifo_cnt;

  assign has_space     = (int'(fifo_cnt) + int'(drain_q_vld)) < (DEPTH + int'(pop));
  assign issue         = drain_go ||
                         ((state == ST_DRAIN) && (issue_cnt < NUM_WORDS_C) && has_space);
  assign drain_rd_addr = drain_go ? '0 : issue_cnt[AW-1:0];

  always_ff @(posedge clock) begin
    if (issue) begin
      drain_q <= mem[drain_rd_addr];
    end
  end

  always_ff @(posedge clock) begin
    if (drain_q_vld) begin
      fifo_mem[wr_ptr] <= drain_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      issue_cnt   <= '0;
      drain_q_vld <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
      drain_index <= '0;
    end else begin
      drain_q_vld <= issue;
      if (issue) begin
        issue_cnt <= drain_go ? (AW+1)'(1) : issue_cnt + (AW+1)'(1);
      end
      if (drain_q_vld) begin
        wr_ptr <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr      <= (rd_ptr == LAST_SLOT) ? '0 : rd_ptr + PW'(1);
        drain_index <= drain_index + AW'(1);
      end
      fifo_cnt <= fifo_cnt + CW'(drain_q_vld) - CW'(pop);
    end
  end

  assign drain_valid = (fifo_cnt != '0);
  assign drain_data  = fifo_mem[rd_ptr];
  assign drain_last  = drain_valid && (drain_index == LAST_IDX);

  // ---------------------------------------------------------------------------
  // Sticky access error
  // ---------------------------------------------------------------------------
`ifdef HISTOGRAM_BIN_MEM_ERR_EN
  logic access;
  assign access = avmm_0_rw_read || avmm_0_rw_write;

  // A bad access in the same cycle as an accepted clear still sets the flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      err <= 1'b0;
    end else if (access && (!in_range || busy)) begin
      err <= 1'b1;
    end else if (clr_go) begin
      err <= 1'b0;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_histogram_bin_mem.sv
// -----------------------------------------------------------------------------
// tb_histogram_bin_mem
//
// Directed bench for histogram_bin_mem with NUM_WORDS=256, BASE_ADDR=0x1000,
// RD_LAT=1. Inputs change 1 time unit after the rising edge; outputs are
// sampled at that same point, so every sample shows the result of the edge
// just taken. Drain beats are checked against an expected queue.
// -----------------------------------------------------------------------------
module tb_histogram_bin_mem;

  localparam int          NW   = 256;
  localparam int          AW   = 8;
  localparam logic [63:0] BASE = 64'h1000;
  localparam int          LAT  = 1;

`ifdef HISTOGRAM_BIN_MEM_ERR_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic [63:0]   address;
  logic [7:0]    byteenable;
  logic          read;
  logic [63:0]   readdata;
  logic          write;
  logic [63:0]   writedata;
  logic          clr_start;
  logic          drain_start;
  logic          busy;
  logic          drain_valid;
  logic          drain_ready;
  logic [63:0]   drain_data;
  logic [AW-1:0] drain_index;
  logic          drain_last;
  logic          err;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [63:0] exp_q[$];

  histogram_bin_mem #(
    .NUM_WORDS (NW),
    .BASE_ADDR (BASE),
    .RD_LAT    (LAT)
  ) dut (
    .clock                (clock),
    .reset                (reset),
    .avmm_0_rw_address    (address),
    .avmm_0_rw_byteenable (byteenable),
    .avmm_0_rw_read       (read),
    .avmm_0_rw_readdata   (readdata),
    .avmm_0_rw_write      (write),
    .avmm_0_rw_writedata  (writedata),
    .clr_start            (clr_start),
    .drain_start          (drain_start),
    .busy                 (busy),
    .drain_valid          (drain_valid),
    .drain_ready          (drain_ready),
    .drain_data           (drain_data),
    .drain_index          (drain_index),
    .drain_last           (drain_last),
    .err                  (err)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Checker
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Drivers
  // ---------------------------------------------------------------------------
  function automatic logic [63:0] addr_of(input int i);
    return BASE + 64'(i) * 64'd8;
  endfunction

  function automatic logic [63:0] pat_val(input int i);
    return 64'hA5A5_0000_0000_0000 | 64'(i * 3);
  endfunction

  task automatic wr(input logic [63:0] a, input logic [63:0] d, input logic [7:0] be);
    address    = a;
    writedata  = d;
    byteenable = be;
    write      = 1'b1;
    tick();
    write      = 1'b0;
  endtask

  task automatic rd(input logic [63:0] a, output logic [63:0] d);
    address = a;
    read    = 1'b1;
    tick();
    read    = 1'b0;
    repeat (LAT - 1) tick();
    d = readdata;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [63:0] d;
    logic [63:0] exp;
    logic [63:0] hold_d;
    logic [AW-1:0] hold_i;
    logic [3:0]  pat;
    logic        have_hold;
    logic        seen_v;
    int          cnt;
    int          nz;
    int          lat;
    int          beats;
    int          gaps;
    int          c;

    reset       = 1'b1;
    address     = '0;
    byteenable  = '0;
    read        = 1'b0;
    write       = 1'b0;
    writedata   = '0;
    clr_start   = 1'b0;
    drain_start = 1'b0;
    drain_ready = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_busy",        busy,        0);
    check("rst_drain_valid", drain_valid, 0);
    check("rst_drain_last",  drain_last,  0);
    check("rst_drain_index", drain_index, 0);
    check("rst_readdata",    readdata,    0);
    check("rst_err",         err,         0);
    reset = 1'b0;
    tick();

    // Bulk clear: busy for exactly NW cycles, every word reads back 0
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    cnt = 0;
    while (busy && cnt < 1000) begin
      cnt++;
      tick();
    end
    check("clr_busy_cycles", cnt, NW);
    nz = 0;
    for (int i = 0; i < NW; i++) begin
      rd(addr_of(i), d);
      if (d != 64'd0) nz++;
    end
    check("clr_all_zero", nz, 0);

    // Basic write/read
    wr(addr_of(1), 64'h11, 8'hFF);
    rd(addr_of(1), d);
    check("rd_after_wr", d, 64'h11);

    // Byte enables: low four bytes replaced
    wr(addr_of(2), 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    wr(addr_of(2), 64'hAABB_CCDD_EEFF_0011, 8'h0F);
    rd(addr_of(2), d);
    check("byteenable_merge", d, 64'hFFFF_FFFF_EEFF_0011);

    // Read and write of the same word in one cycle returns the old value
    wr(addr_of(3), 64'h1234_5678_9ABC_DEF0, 8'hFF);
    address    = addr_of(3);
    writedata  = 64'h0F0F;
    byteenable = 8'hFF;
    write      = 1'b1;
    read       = 1'b1;
    tick();
    write = 1'b0;
    read  = 1'b0;
    check("rd_wr_same_old", readdata, 64'h1234_5678_9ABC_DEF0);
    rd(addr_of(3), d);
    check("rd_wr_same_new", d, 64'h0F0F);

    // Back-to-back reads, one per cycle
    read = 1'b1;
    address = addr_of(1); tick(); check("pipe_rd_1", readdata, 64'h11);
    address = addr_of(2); tick(); check("pipe_rd_2", readdata, 64'hFFFF_FFFF_EEFF_0011);
    address = addr_of(3); tick(); check("pipe_rd_3", readdata, 64'h0F0F);
    read = 1'b0;
    tick();
    check("rd_idle_zero", readdata, 0);

    // Out of range: reads give 0, writes do not alias onto real bins
    rd(addr_of(NW), d);
    check("oob_rd_zero", d, 0);
    check("oob_rd_err", err, ERR_ON);
    wr(addr_of(NW), 64'hDEAD_0000_0000_0001, 8'hFF);
    wr(BASE - 64'd8, 64'hDEAD_0000_0000_0002, 8'hFF);
    rd(BASE - 64'd8, d);
    check("below_base_rd_zero", d, 0);
    rd(addr_of(0), d);
    check("oob_wr_word0", d, 0);
    rd(addr_of(NW - 1), d);
    check("oob_wr_word_last", d, 0);

    // clr_start and drain_start together: clear wins, no drain follows
    clr_start   = 1'b1;
    drain_start = 1'b1;
    drain_ready = 1'b1;
    tick();
    clr_start   = 1'b0;
    drain_start = 1'b0;
    check("clr_accept_err_clear", err, 0);
    cnt = 0;
    seen_v = 1'b0;
    while (busy && cnt < 1000) begin
      cnt++;
      if (drain_valid) seen_v = 1'b1;
      tick();
    end
    repeat (4) begin
      if (drain_valid) seen_v = 1'b1;
      tick();
    end
    check("both_start_busy_cycles", cnt, NW);
    check("both_start_no_drain", seen_v, 0);
    rd(addr_of(1), d);
    check("both_start_cleared", d, 0);

    // Drain with ready held high
    for (int i = 0; i < NW; i++) begin
      wr(addr_of(i), 64'(i), 8'hFF);
      exp_q.push_back(64'(i));
    end
    drain_ready = 1'b1;
    drain_start = 1'b1;
    tick();
    drain_start = 1'b0;
    check("drain_busy", busy, 1);
    lat = 1;
    while (!drain_valid && lat < 50) begin
      tick();
      lat++;
    end
    check("drain_first_latency_ok", lat <= LAT + 1, 1);
    beats = 0;
    gaps  = 0;
    c     = 0;
    while (beats < NW && c < 2000) begin
      if (drain_valid) begin
        exp = exp_q.pop_front();
        check("drain_data", drain_data, exp);
        check("drain_index", drain_index, beats);
        check("drain_last", drain_last, beats == NW - 1);
        beats++;
      end else begin
        gaps++;
      end
      c++;
      tick();
    end
    check("drain_beats", beats, NW);
    check("drain_gaps", gaps, 0);
    check("drain_done_busy", busy, 0);
    check("drain_done_valid", drain_valid, 0);

    // Drain with ready toggling 1-0-0-1, plus AVMM accesses while busy
    exp_q.delete();
    for (int i = 0; i < NW; i++) begin
      wr(addr_of(i), pat_val(i), 8'hFF);
      exp_q.push_back(pat_val(i));
    end
    pat = 4'b1001;
    drain_ready = 1'b0;
    drain_start = 1'b1;
    tick();
    drain_start = 1'b0;
    beats = 0;
    c = 0;
    have_hold = 1'b0;
    hold_d = '0;
    hold_i = '0;
    while (beats < NW && c < 3000) begin
      drain_ready = pat[c % 4];
      write       = (c == 3);
      read        = (c == 6);
      address     = (c == 3) ? addr_of(5) : addr_of(6);
      writedata   = 64'hBAD0_BAD0_BAD0_BAD0;
      byteenable  = 8'hFF;
      if (c == 7) check("busy_rd_zero", readdata, 0);
      if (have_hold) begin
        check("stall_valid", drain_valid, 1);
        check("stall_data", drain_data, hold_d);
        check("stall_index", drain_index, hold_i);
      end
      if (drain_valid && drain_ready) begin
        exp = exp_q.pop_front();
        check("toggle_data", drain_data, exp);
        check("toggle_index", drain_index, beats);
        beats++;
      end
      have_hold = drain_valid && !drain_ready;
      hold_d    = drain_data;
      hold_i    = drain_index;
      c++;
      tick();
    end
    write = 1'b0;
    read  = 1'b0;
    check("toggle_beats", beats, NW);
    check("toggle_done_busy", busy, 0);
    check("busy_access_err", err, ERR_ON);
    rd(addr_of(5), d);
    check("busy_wr_dropped", d, pat_val(5));

    // Reset in the middle of a drain
    drain_ready = 1'b1;
    drain_start = 1'b1;
    tick();
    drain_start = 1'b0;
    beats = 0;
    c = 0;
    while (beats < 10 && c < 200) begin
      if (drain_valid) beats++;
      c++;
      tick();
    end
    check("mid_drain_beats", beats, 10);
    check("mid_drain_busy", busy, 1);
    reset = 1'b1;
    tick();
    check("abort_busy", busy, 0);
    check("abort_valid", drain_valid, 0);
    check("abort_index", drain_index, 0);
    check("abort_err", err, 0);
    reset = 1'b0;
    tick();
    check("abort_valid_after", drain_valid, 0);
    rd(addr_of(7), d);
    check("abort_ram_kept", d, pat_val(7));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
